// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core (A) and debug/loader (B) share one memory port.
// Fair tie-break on last grant, optional bounded grant locking, one-cycle read return.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [3:0]        a_mask,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [3:0]        b_mask,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic [3:0]        mem_sign_mask,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
  // A lock of length one releases on the same edge it would start, so never enter LOCK_x.
  localparam logic LOCK_EN = (MAX_LOCK > 1);

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic              last_b_r, last_b_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s, inc_s;
  logic              arb_a_s, arb_b_s;
  logic              a_gnt_s, b_gnt_s;
  logic              a_rvalid_r, b_rvalid_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= MAX_CNT) begin
      sat_inc = MAX_CNT;
    end else begin
      sat_inc = v + ONE_CNT;
    end
  endfunction

  // Open arbitration: lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    arb_a_s = 1'b0;
    arb_b_s = 1'b0;
    if (a_req && b_req) begin
      arb_a_s = last_b_r;
      arb_b_s = ~last_b_r;
    end else begin
      arb_a_s = a_req;
      arb_b_s = b_req;
    end
  end

  // Grant selection; a locked port pre-empts the other only while it is requesting.
  always_comb begin
    a_gnt_s = 1'b0;
    b_gnt_s = 1'b0;
    if (rst) begin
      a_gnt_s = 1'b0;
      b_gnt_s = 1'b0;
    end else begin
      case (state_r)
        ARB: begin
          a_gnt_s = arb_a_s;
          b_gnt_s = arb_b_s;
        end
        LOCK_A: begin
          if (a_req) begin
            a_gnt_s = 1'b1;
          end else begin
            b_gnt_s = b_req;
          end
        end
        LOCK_B: begin
          if (b_req) begin
            b_gnt_s = 1'b1;
          end else begin
            a_gnt_s = a_req;
          end
        end
        default: begin
          a_gnt_s = arb_a_s;
          b_gnt_s = arb_b_s;
        end
      endcase
    end
  end

  // Next state, lock counter and last-grant tracking.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    inc_s    = cnt_r;
    last_b_s = last_b_r;
    if (a_gnt_s) begin
      last_b_s = 1'b0;
    end else if (b_gnt_s) begin
      last_b_s = 1'b1;
    end else begin
      last_b_s = last_b_r;
    end
    case (state_r)
      ARB: begin
        if (LOCK_EN && a_gnt_s && a_lock) begin
          state_s = LOCK_A;
          cnt_s   = ONE_CNT;
        end else if (LOCK_EN && b_gnt_s && b_lock) begin
          state_s = LOCK_B;
          cnt_s   = ONE_CNT;
        end else begin
          cnt_s   = {CNT_W{1'b0}};
        end
      end
      LOCK_A: begin
        inc_s = a_gnt_s ? sat_inc(cnt_r) : cnt_r;
        if (!a_lock || (inc_s == MAX_CNT)) begin
          state_s = ARB;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s   = inc_s;
        end
      end
      LOCK_B: begin
        inc_s = b_gnt_s ? sat_inc(cnt_r) : cnt_r;
        if (!b_lock || (inc_s == MAX_CNT)) begin
          state_s = ARB;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s   = inc_s;
        end
      end
      default: begin
        state_s = ARB;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers; the rvalid tags only track reads issued, never FSM moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ARB;
      last_b_r   <= 1'b1;
      cnt_r      <= {CNT_W{1'b0}};
      a_rvalid_r <= 1'b0;
      b_rvalid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      last_b_r   <= last_b_s;
      cnt_r      <= cnt_s;
      a_rvalid_r <= a_gnt_s & ~a_we;
      b_rvalid_r <= b_gnt_s & ~b_we;
    end
  end

  assign a_gnt          = a_gnt_s;
  assign b_gnt          = b_gnt_s;
  assign a_rvalid       = a_rvalid_r;
  assign b_rvalid       = b_rvalid_r;
  assign a_rdata        = mem_read_data;
  assign b_rdata        = mem_read_data;
  // Memory-side fields default to port A when nothing is granted.
  assign mem_addr       = b_gnt_s ? b_addr  : a_addr;
  assign mem_write_data = b_gnt_s ? b_wdata : a_wdata;
  assign mem_sign_mask  = b_gnt_s ? b_mask  : a_mask;
  assign mem_memwrite   = (a_gnt_s & a_we)  | (b_gnt_s & b_we);
  assign mem_memread    = (a_gnt_s & ~a_we) | (b_gnt_s & ~b_we);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (MAX_LOCK=4): reads, writes, ties, locking and reset.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int ML = 4;

  logic          clk, rst;
  logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [AW-1:0] a_addr, b_addr, mem_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_write_data, mem_read_data;
  logic [3:0]    a_mask, b_mask, mem_sign_mask;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, mem_memwrite, mem_memread;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_mask(a_mask), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_mask(b_mask), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0; a_addr = 32'h0; a_wdata = 32'h0; a_mask = 4'h0;
    b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = 32'h0; b_wdata = 32'h0; b_mask = 4'h0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  bit exp_a, prev_a, prev_b;

  initial begin
    rst = 1'b1;
    idle_all();
    mem_read_data = 32'hDEAD_BEEF;
    a_req = 1'b1; b_req = 1'b1;
    #2;
    check("rst_a_gnt", a_gnt, 1'b0);
    check("rst_b_gnt", b_gnt, 1'b0);
    check("rst_memread", mem_memread, 1'b0);
    check("rst_memwrite", mem_memwrite, 1'b0);
    tick();
    check("rst_a_rvalid", a_rvalid, 1'b0);
    check("rst_b_rvalid", b_rvalid, 1'b0);
    idle_all();
    rst = 1'b0;

    // Single read from A
    a_req = 1'b1; a_addr = 32'h10;
    #1;
    check("rd_a_gnt", a_gnt, 1'b1);
    check("rd_b_gnt", b_gnt, 1'b0);
    check("rd_memread", mem_memread, 1'b1);
    check("rd_memwrite", mem_memwrite, 1'b0);
    check("rd_addr", mem_addr, 32'h10);
    tick();
    a_req = 1'b0;
    check("rd_a_rvalid", a_rvalid, 1'b1);
    check("rd_a_rdata", a_rdata, 32'hDEAD_BEEF);
    check("rd_b_rvalid", b_rvalid, 1'b0);
    mem_read_data = 32'h1234_5678;
    #1;
    check("rd_b_rdata_comb", b_rdata, 32'h1234_5678);
    tick();
    check("rd_rvalid_once", a_rvalid, 1'b0);

    // Both read every cycle from reset: alternate A,B,...
    do_reset();
    a_req = 1'b1; b_req = 1'b1; a_addr = 32'h100; b_addr = 32'h200;
    prev_a = 1'b0; prev_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_a = (i % 2 == 0);
      #1;
      check("alt_a_gnt", a_gnt, exp_a);
      check("alt_b_gnt", b_gnt, !exp_a);
      check("alt_excl", a_gnt & b_gnt, 1'b0);
      check("alt_addr", mem_addr, exp_a ? 32'h100 : 32'h200);
      check("alt_a_rvalid", a_rvalid, prev_a);
      check("alt_b_rvalid", b_rvalid, prev_b);
      prev_a = exp_a; prev_b = !exp_a;
      tick();
    end
    idle_all();

    // B write with A idle; last grant becomes B
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h2000; b_wdata = 32'h55; b_mask = 4'hF;
    a_addr = 32'h44; a_mask = 4'h3;
    #1;
    check("wr_b_gnt", b_gnt, 1'b1);
    check("wr_a_gnt", a_gnt, 1'b0);
    check("wr_memwrite", mem_memwrite, 1'b1);
    check("wr_memread", mem_memread, 1'b0);
    check("wr_data", mem_write_data, 32'h55);
    check("wr_addr", mem_addr, 32'h2000);
    check("wr_mask", mem_sign_mask, 4'hF);
    tick();
    b_req = 1'b0;
    #1;
    check("wr_no_b_rvalid", b_rvalid, 1'b0);
    check("wr_no_a_rvalid", a_rvalid, 1'b0);
    check("idle_addr_a", mem_addr, 32'h44);
    check("idle_mask_a", mem_sign_mask, 4'h3);
    check("idle_memwrite", mem_memwrite, 1'b0);
    tick();
    idle_all();

    // B locks continuously with A waiting: 4 B grants then A
    b_req = 1'b1; b_lock = 1'b1; b_we = 1'b1;
    for (int i = 0; i < ML; i++) begin
      #1;
      check("lockb_b_gnt", b_gnt, 1'b1);
      check("lockb_a_gnt", a_gnt, 1'b0);
      tick();
      a_req = 1'b1; a_we = 1'b1;
    end
    #1;
    check("lockb_rel_a", a_gnt, 1'b1);
    check("lockb_rel_b", b_gnt, 1'b0);
    tick();
    b_lock = 1'b0; b_req = 1'b0;
    #1;
    check("lockb_arb_a_alone", a_gnt, 1'b1);
    tick();
    idle_all();

    // Lock released by dropping lock: tie then goes to A
    b_req = 1'b1; b_lock = 1'b1; b_we = 1'b1;
    #1;
    check("unlk_b_first", b_gnt, 1'b1);
    tick();
    b_lock = 1'b0; a_req = 1'b1; a_we = 1'b1;
    #1;
    check("unlk_b_held", b_gnt, 1'b1);
    tick();
    #1;
    check("unlk_a_tie", a_gnt, 1'b1);
    tick();
    idle_all();

    // Lock A; A drops req for a cycle while B requests
    a_req = 1'b1; a_lock = 1'b1; a_we = 1'b1;
    #1;
    check("locka_a0", a_gnt, 1'b1);
    tick();
    a_req = 1'b0; b_req = 1'b1; b_we = 1'b1;
    #1;
    check("locka_gap_b", b_gnt, 1'b1);
    check("locka_gap_a", a_gnt, 1'b0);
    tick();
    a_req = 1'b1;
    #1;
    check("locka_back_a", a_gnt, 1'b1);
    check("locka_back_b", b_gnt, 1'b0);
    tick();
    a_lock = 1'b0;
    #1;
    check("locka_last_a", a_gnt, 1'b1);
    tick();
    #1;
    check("locka_after_b", b_gnt, 1'b1);
    tick();
    idle_all();

    // Reset pulsed while a read is granted
    a_req = 1'b1;
    #1;
    check("rstp_gnt_before", a_gnt, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("rstp_a_gnt", a_gnt, 1'b0);
    check("rstp_memread", mem_memread, 1'b0);
    tick();
    check("rstp_rvalid", a_rvalid, 1'b0);
    check("rstp_gnt_held", a_gnt, 1'b0);
    b_req = 1'b1;
    rst = 1'b0;
    #1;
    check("rstp_tie_a", a_gnt, 1'b1);
    check("rstp_tie_b", b_gnt, 1'b0);
    b_req = 1'b0;
    tick();
    check("rstp2_rvalid_set", a_rvalid, 1'b1);
    a_req = 1'b0;
    rst = 1'b1;
    #1;
    check("rstp2_rvalid_clr", a_rvalid, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("rstp2_no_gnt", a_gnt | b_gnt, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_W, 32, address width; DATA_W, 32, data width; MAX_LOCK, 16, maximum consecutive locked grants to one port.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a_req  in  1  core port request
- a_we  in  1  core write (1) / read (0)
- a_lock  in  1  core requests grant hold
- a_addr  in  ADDR_W  core word address
- a_wdata  in  DATA_W  core write data
- a_mask  in  4  core sign_mask
- a_gnt  out  1  core access issued this cycle
- a_rvalid  out  1  core read data valid
- a_rdata  out  DATA_W  core read data
- b_req, b_we, b_lock, b_addr, b_wdata, b_mask, b_gnt, b_rvalid, b_rdata: same as a_*, for the debug/loader port
- mem_addr  out  ADDR_W  to data memory addr
- mem_write_data  out  DATA_W  to data memory write_data
- mem_memwrite  out  1  to data memory memwrite
- mem_memread  out  1  to data memory memread
- mem_sign_mask  out  4  to data memory sign_mask
- mem_read_data  in  DATA_W  from data memory, registered, valid one cycle after memread

Function
REQ-003 At most one of a_gnt, b_gnt SHALL be high in any cycle; a grant SHALL only be given to a port whose req is high.
REQ-004 Grants SHALL be combinational from req and registered state; an access completes at the rising edge where gnt is high; requester holds req/addr/we/wdata/mask stable until then.
REQ-005 mem_addr, mem_write_data, mem_sign_mask SHALL follow the granted port; with no grant they SHALL follow port A; mem_memwrite = gnt & we, mem_memread = gnt & ~we of the granted port; both 0 with no grant.
REQ-006 Read latency SHALL be one cycle: a read granted in cycle N gives x_rvalid=1 for exactly cycle N+1 on the same port, x_rdata = mem_read_data.
REQ-007 x_rdata SHALL equal mem_read_data combinationally on both ports; only rvalid qualifies it.
REQ-008 Writes SHALL produce no rvalid.
REQ-009 State machine SHALL have states ARB, LOCK_A, LOCK_B.
REQ-010 ARB: single requester is granted; both requesting -> grant the port not granted most recently (last-grant register, reset value B so A wins first tie).
REQ-011 ARB -> LOCK_x at the edge where x is granted with x_lock=1; lock counter loaded with 1.
REQ-012 LOCK_x: port x SHALL be granted whenever x_req=1; other port SHALL NOT be granted while x_req=1; if x_req=0 the other port MAY be granted per REQ-010 without leaving LOCK_x.
REQ-013 LOCK_x -> ARB when x_lock=0 at a clock edge, or when counter reaches MAX_LOCK; counter increments per grant to x, saturates at MAX_LOCK.
REQ-014 Forced release at MAX_LOCK: last-grant SHALL be x, so a waiting other port wins the next tie.
REQ-015 Last-grant register SHALL update on every grant.
REQ-016 rvalid pipeline SHALL be a registered per-port tag, independent of state transitions.

Reset
REQ-017 rst high SHALL asynchronously set state=ARB, last-grant=B, lock counter=0, a_rvalid=b_rvalid=0.
REQ-018 While rst high, a_gnt=b_gnt=0, mem_memwrite=mem_memread=0.
REQ-019 Reset asserted one cycle after a granted read SHALL suppress that rvalid; no access is issued on the deassertion edge unless req is high after release.

Verification
REQ-020 A reads addr 0x10 alone -> a_gnt=1 same cycle, mem_memread=1, mem_addr=0x10; next cycle a_rvalid=1, a_rdata=mem_read_data, b_rvalid=0.
REQ-021 A and B both request reads every cycle from reset -> grants alternate A,B,A,B; never both high.
REQ-022 B writes 0x2000 data 0x55 with A idle -> b_gnt=1, mem_memwrite=1, mem_write_data=0x55, no rvalid.
REQ-023 B lock=1 continuous, A requesting, MAX_LOCK=4 -> B granted 4 cycles, then A granted next, state ARB.
REQ-024 Lock A, A drops req for one cycle while B requests -> B granted that cycle, A regains grant when req returns.
REQ-025 rst pulsed mid-cycle after a granted read -> rvalid stays 0, gnt 0 during reset, first tie after release granted to A.
